fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Parametrised next-generation instruction fetch sequencer.
- Holds the program counter and presents it as the instruction number to the instruction ROM each cycle.
- Supports sequential, PC-relative branch, absolute jump, call/return via a hardware return-address stack (RAS), stall, and a latched halt state in place of simulation termination.
- Provides saturating cycle and retired-instruction counters for performance reporting.

Parameters:
- PC_WIDTH, 8, width of PC, branch offset and jump target.
- CNT_WIDTH, 17, width of cycle and instruction counters.
- RAS_DEPTH, 4, return-address stack entries (>=1).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and all state this cycle (counters excepted, see below).
- branch_ctrl  in  1  take PC-relative branch.
- branch_offset  in  PC_WIDTH  signed two's-complement offset.
- jump_ctrl  in  1  absolute jump.
- call_ctrl  in  1  push return address, then jump.
- ret_ctrl  in  1  pop return address into PC.
- jump_target  in  PC_WIDTH  target for jump_ctrl and call_ctrl.
- done_ctrl  in  1  current instruction is the last; halt.
- instruction_number  out  PC_WIDTH  current PC (registered).
- halted  out  1  sequencer is in HALTED.
- cycle_counter  out  CNT_WIDTH  cycles since reset.
- instr_counter  out  CNT_WIDTH  instructions retired since reset.
- ras_overflow  out  1  sticky: push attempted on a full stack.
- ras_underflow  out  1  sticky: pop attempted on an empty stack.

Behaviour:
- Reset (sampled at the rising edge; wins over everything):
  - instruction_number=RESET_PC, halted=0, both counters=0, RAS empty, both sticky flags=0, state=RUN.
  - Reset asserted mid-operation or while HALTED behaves identically.
- States:
  - RUN: normal fetching.
  - HALTED: entered from RUN on done_ctrl & !stall; left only via reset.
- Control inputs always refer to the instruction whose number is on instruction_number this cycle. The new PC is visible the cycle after the edge (one-cycle latency). No combinational path from inputs to outputs.
- RUN next-PC priority, highest first:
  1. stall: PC, RAS and state hold; instr_counter holds.
  2. done_ctrl: go to HALTED; PC holds; instr_counter +1.
  3. branch_ctrl: PC = PC + sign-extended branch_offset, modulo 2^PC_WIDTH.
  4. jump_ctrl: PC = jump_target.
  5. call_ctrl:
     - Push (PC+1) mod 2^PC_WIDTH, then PC = jump_target.
     - If the RAS is full, the push is dropped, ras_overflow is set, and the jump still happens.
  6. ret_ctrl:
     - If the RAS is non-empty, PC = popped top entry.
     - If the RAS is empty, PC = PC+1 and ras_underflow is set.
  7. otherwise: PC = PC+1, wrapping from all-ones to 0.
- Simultaneous controls: a lower-priority control is ignored entirely. A branch together with a call does not push. A jump together with a ret does not pop.
- instr_counter increments once per non-stalled RUN cycle, including the done cycle.
- HALTED:
  - PC, RAS and instr_counter frozen.
  - All controls ignored, including stall.
  - halted=1 from the cycle after the done edge.
- cycle_counter increments every non-reset cycle in RUN (stalled or not) and freezes in HALTED.
- Both counters saturate at all-ones and never wrap.
- RAS:
  - LIFO with pointer width clog2(RAS_DEPTH+1).
  - Full means RAS_DEPTH entries; empty means 0 entries.
  - Contents are not observable except via ret.
- Sticky flags clear only on reset.

Test Plan:
- Reset, then 5 idle cycles -> instruction_number 0,1,2,3,4,5; cycle_counter=5; instr_counter=5; halted=0.
- At PC=10, branch_ctrl with offset 0xFD (-3) -> next PC=7.
- At PC=250, branch offset +10 (PC_WIDTH=8) -> PC=4 (wrap).
- At PC=3, call_ctrl with target 40; at PC=41, ret_ctrl -> PC sequence 3,40,41,4.
- With RAS_DEPTH=4, 5 nested calls -> ras_overflow=1 after the 5th. 5 rets return to the 4 pushed addresses, then the 5th gives PC+1 and ras_underflow=1.
- stall held 3 cycles at PC=6 -> PC stays 6; cycle_counter +3; instr_counter +0.
- At PC=20, assert done_ctrl with jump_ctrl also high -> halted=1 and PC stays 20 for 10 cycles; counters frozen. Then reset -> PC=0, counters 0, halted=0.
- Simultaneous branch_ctrl+call_ctrl -> branch taken, RAS depth unchanged.
- Preload cycle_counter near max (CNT_WIDTH=4 build) -> holds at 15.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Control/status bundle between an instruction decoder (master) and the
// fetch sequencer (slave).
interface fetch_sequencer_if #(
    parameter int PC_WIDTH  = 8,
    parameter int CNT_WIDTH = 17
);
    logic                 stall;
    logic                 branch_ctrl;
    logic [PC_WIDTH-1:0]  branch_offset;
    logic                 jump_ctrl;
    logic                 call_ctrl;
    logic                 ret_ctrl;
    logic [PC_WIDTH-1:0]  jump_target;
    logic                 done_ctrl;
    logic [PC_WIDTH-1:0]  instruction_number;
    logic                 halted;
    logic [CNT_WIDTH-1:0] cycle_counter;
    logic [CNT_WIDTH-1:0] instr_counter;
    logic                 ras_overflow;
    logic                 ras_underflow;

    modport master (
        output stall, branch_ctrl, branch_offset, jump_ctrl, call_ctrl,
               ret_ctrl, jump_target, done_ctrl,
        input  instruction_number, halted, cycle_counter, instr_counter,
               ras_overflow, ras_underflow
    );

    modport slave (
        input  stall, branch_ctrl, branch_offset, jump_ctrl, call_ctrl,
               ret_ctrl, jump_target, done_ctrl,
        output instruction_number, halted, cycle_counter, instr_counter,
               ras_overflow, ras_underflow
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC with branch/jump/call/ret, a return-address
// stack, a latched halt state and saturating performance counters.
module fetch_sequencer #(
    parameter int                  PC_WIDTH  = 8,
    parameter int                  CNT_WIDTH = 17,
    parameter int                  RAS_DEPTH = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
    input logic              clock,
    input logic              reset,
    fetch_sequencer_if.slave bus
);
    localparam int PTR_W = $clog2(RAS_DEPTH + 1);
    localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int SLOTS = 2 ** IDX_W;

    localparam logic [PC_WIDTH-1:0]  PC_ONE  = 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
    localparam logic [PTR_W-1:0]     PTR_ONE = 1;
    localparam logic [PTR_W-1:0]     PTR_FULL = PTR_W'(RAS_DEPTH);

    typedef enum logic {RUN, HALTED} state_t;

    state_t               state, state_next;
    logic [PC_WIDTH-1:0]  pc, pc_next;
    logic [CNT_WIDTH-1:0] cycle_cnt, instr_cnt;
    logic                 ovf_flag, unf_flag;
    logic [PC_WIDTH-1:0]  ras_mem [SLOTS];
    logic [PTR_W-1:0]     ras_ptr, ptr_dec;
    logic [IDX_W-1:0]     top_idx, push_idx;
    logic                 ras_full, ras_empty;
    logic                 push, pop, ovf_set, unf_set, retire;

    assign ras_full  = (ras_ptr == PTR_FULL);
    assign ras_empty = (ras_ptr == '0);
    assign ptr_dec   = ras_ptr - PTR_ONE;
    assign top_idx   = ptr_dec[IDX_W-1:0];
    assign push_idx  = ras_ptr[IDX_W-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= RUN;
            pc        <= RESET_PC;
            ras_ptr   <= '0;
            cycle_cnt <= '0;
            instr_cnt <= '0;
            ovf_flag  <= 1'b0;
            unf_flag  <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (push)
                ras_ptr <= ras_ptr + PTR_ONE;
            else if (pop)
                ras_ptr <= ptr_dec;
            if (state == RUN && cycle_cnt != '1)
                cycle_cnt <= cycle_cnt + CNT_ONE;
            if (retire && instr_cnt != '1)
                instr_cnt <= instr_cnt + CNT_ONE;
            if (ovf_set) ovf_flag <= 1'b1;
            if (unf_set) unf_flag <= 1'b1;
        end
    end

    // NOTE: stack storage has no reset; an entry is only read after a push
    // wrote it, so clearing it would add reset fan-out for nothing.
    always_ff @(posedge clock) begin
        if (push && !reset)
            ras_mem[push_idx] <= pc + PC_ONE;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        push       = 1'b0;
        pop        = 1'b0;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;
        retire     = 1'b0;
        if (state == RUN && !bus.stall) begin
            retire = 1'b1;
            if (bus.done_ctrl) begin
                state_next = HALTED;
            end else if (bus.branch_ctrl) begin
                // Same-width add is the sign-extended add modulo 2^PC_WIDTH.
                pc_next = pc + bus.branch_offset;
            end else if (bus.jump_ctrl) begin
                pc_next = bus.jump_target;
            end else if (bus.call_ctrl) begin
                pc_next = bus.jump_target;
                if (ras_full) ovf_set = 1'b1;
                else          push    = 1'b1;
            end else if (bus.ret_ctrl) begin
                if (ras_empty) begin
                    pc_next = pc + PC_ONE;
                    unf_set = 1'b1;
                end else begin
                    pc_next = ras_mem[top_idx];
                    pop     = 1'b1;
                end
            end else begin
                pc_next = pc + PC_ONE;
            end
        end
    end

    always_comb begin
        bus.instruction_number = pc;
        bus.halted             = (state == HALTED);
        bus.cycle_counter      = cycle_cnt;
        bus.instr_counter      = instr_cnt;
        bus.ras_overflow       = ovf_flag;
        bus.ras_underflow      = unf_flag;
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: main 17-bit-counter build plus a
// 4-bit-counter build used to observe counter saturation.
module tb_fetch_sequencer;
    logic clock = 1'b0;
    logic reset;
    logic reset4;

    always #5 clock = ~clock;

    fetch_sequencer_if #(.PC_WIDTH(8), .CNT_WIDTH(17)) bus ();
    fetch_sequencer_if #(.PC_WIDTH(8), .CNT_WIDTH(4))  bus4 ();

    fetch_sequencer #(.PC_WIDTH(8), .CNT_WIDTH(17), .RAS_DEPTH(4), .RESET_PC(8'd0)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    fetch_sequencer #(.PC_WIDTH(8), .CNT_WIDTH(4), .RAS_DEPTH(4), .RESET_PC(8'd0)) dut4 (
        .clock (clock),
        .reset (reset4),
        .bus   (bus4.slave)
    );

    int compared   = 0;
    int mismatched = 0;
    int exp_cyc    = 0;
    int exp_ins    = 0;
    bit exp_halt   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge, updating the expected counter model from the inputs
    // the DUT sampled at that edge, then settle past the edge.
    task automatic tick();
        @(posedge clock);
        if (reset) begin
            exp_cyc  = 0;
            exp_ins  = 0;
            exp_halt = 1'b0;
        end else if (!exp_halt) begin
            exp_cyc++;
            if (!bus.stall) begin
                exp_ins++;
                if (bus.done_ctrl) exp_halt = 1'b1;
            end
        end
        #1;
    endtask

    task automatic drive(input logic st, input logic br, input logic [7:0] off,
                         input logic jmp, input logic cl, input logic rt,
                         input logic [7:0] tgt, input logic dn);
        bus.stall         = st;
        bus.branch_ctrl   = br;
        bus.branch_offset = off;
        bus.jump_ctrl     = jmp;
        bus.call_ctrl     = cl;
        bus.ret_ctrl      = rt;
        bus.jump_target   = tgt;
        bus.done_ctrl     = dn;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic check_state(input string tag, input logic [7:0] pc);
        check({tag, ".pc"},     32'(bus.instruction_number), 32'(pc));
        check({tag, ".cycles"}, 32'(bus.cycle_counter),      32'(exp_cyc));
        check({tag, ".instrs"}, 32'(bus.instr_counter),      32'(exp_ins));
        check({tag, ".halted"}, 32'(bus.halted),             32'(exp_halt));
    endtask

    task automatic step_call(input logic [7:0] tgt);
        drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, tgt, 1'b0);
        tick();
        idle();
    endtask

    task automatic step_ret();
        drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0);
        tick();
        idle();
    endtask

    task automatic step_jump(input logic [7:0] tgt);
        drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, tgt, 1'b0);
        tick();
        idle();
    endtask

    initial begin
        bus4.stall = 1'b0;       bus4.branch_ctrl = 1'b0; bus4.branch_offset = 8'd0;
        bus4.jump_ctrl = 1'b0;   bus4.call_ctrl = 1'b0;   bus4.ret_ctrl = 1'b0;
        bus4.jump_target = 8'd0; bus4.done_ctrl = 1'b0;
        idle();
        reset  = 1'b1;
        reset4 = 1'b1;
        tick();
        tick();
        reset  = 1'b0;
        reset4 = 1'b0;

        // Reset state, then five sequential fetches.
        check_state("reset", 8'd0);
        check("reset.ovf", 32'(bus.ras_overflow), 32'd0);
        check("reset.unf", 32'(bus.ras_underflow), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("seq.pc", 32'(bus.instruction_number), 32'(i));
        end
        check_state("idle5", 8'd5);

        // Backward branch by -3 from PC 10.
        repeat (5) tick();
        check("at10.pc", 32'(bus.instruction_number), 32'd10);
        drive(1'b0, 1'b1, 8'hFD, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        tick();
        idle();
        check_state("branch_back", 8'd7);

        // Absolute jump to 250, then forward branch wraps to 4.
        step_jump(8'd250);
        check("jump.pc", 32'(bus.instruction_number), 32'd250);
        drive(1'b0, 1'b1, 8'd10, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        tick();
        idle();
        check("branch_wrap.pc", 32'(bus.instruction_number), 32'd4);

        // Call at 3 to 40, return from 41 lands on 4.
        step_jump(8'd3);
        check("call_at.pc", 32'(bus.instruction_number), 32'd3);
        step_call(8'd40);
        check("call.pc", 32'(bus.instruction_number), 32'd40);
        tick();
        check("callee.pc", 32'(bus.instruction_number), 32'd41);
        step_ret();
        check_state("ret", 8'd4);

        // Five nested calls into a four-entry stack; the fifth push drops.
        step_call(8'd50);
        step_call(8'd60);
        step_call(8'd70);
        step_call(8'd80);
        check("nest4.ovf", 32'(bus.ras_overflow), 32'd0);
        step_call(8'd90);
        check("nest5.pc", 32'(bus.instruction_number), 32'd90);
        check("nest5.ovf", 32'(bus.ras_overflow), 32'd1);
        step_ret();
        check("ret1.pc", 32'(bus.instruction_number), 32'd71);
        step_ret();
        check("ret2.pc", 32'(bus.instruction_number), 32'd61);
        step_ret();
        check("ret3.pc", 32'(bus.instruction_number), 32'd51);
        step_ret();
        check("ret4.pc", 32'(bus.instruction_number), 32'd5);
        check("ret4.unf", 32'(bus.ras_underflow), 32'd0);
        step_ret();
        check("ret5.pc", 32'(bus.instruction_number), 32'd6);
        check("ret5.unf", 32'(bus.ras_underflow), 32'd1);
        check_state("after_rets", 8'd6);

        // Three-cycle stall at PC 6; a branch under stall is ignored.
        drive(1'b1, 1'b1, 8'd9, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall.pc", 32'(bus.instruction_number), 32'd6);
        end
        idle();
        check_state("stall_end", 8'd6);

        // Jump with ret: jump wins and the stack is not popped.
        step_call(8'd30);
        drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 8'd35, 1'b0);
        tick();
        idle();
        check("jump_ret.pc", 32'(bus.instruction_number), 32'd35);
        step_ret();
        check("kept_entry.pc", 32'(bus.instruction_number), 32'd7);

        // Branch with call: branch wins and nothing is pushed.
        drive(1'b0, 1'b1, 8'd5, 1'b0, 1'b1, 1'b0, 8'd99, 1'b0);
        tick();
        idle();
        check("branch_call.pc", 32'(bus.instruction_number), 32'd12);
        step_ret();
        check("no_push.pc", 32'(bus.instruction_number), 32'd13);

        // Done together with jump at PC 20: halt, then everything frozen.
        step_jump(8'd20);
        drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd77, 1'b1);
        tick();
        check_state("halt", 8'd20);
        for (int i = 0; i < 10; i++) begin
            drive(i[0], 1'b1, 8'd3, 1'b1, 1'b1, 1'b1, 8'd60, i[1]);
            tick();
            check_state("halted", 8'd20);
        end
        idle();

        // Reset out of HALTED.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_state("rehalt_reset", 8'd0);
        check("rst.ovf", 32'(bus.ras_overflow), 32'd0);
        check("rst.unf", 32'(bus.ras_underflow), 32'd0);
        tick();
        check_state("post_reset", 8'd1);

        // Narrow-counter build has run far past 15 cycles since its reset.
        check("sat.cycles", 32'(bus4.cycle_counter), 32'd15);
        check("sat.instrs", 32'(bus4.instr_counter), 32'd15);
        check("sat.halted", 32'(bus4.halted), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
